multi_digit_counter: RTL and testbench

MULTI_DIGIT_COUNTER -- requirements
Module: multi_digit_counter

---
 rtl/digi_pkg.sv | 34 +++
 rtl/bin2bcd_seq.sv | 82 ++++++++
 rtl/multi_digit_counter.sv | 173 +++++++++++++++++
 tb/tb_multi_digit_counter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/digi_pkg.sv
// Shared definitions for the multi-digit counter display: 7-segment code
// table, blank pattern and the BCD conversion FSM state encoding.
package digi_pkg;

    // Active-low segments, bit7 = dp, bits6..0 = g..a. All ones = all off.
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        BCD_IDLE  = 2'd0,
        BCD_SHIFT = 2'd1,
        BCD_DONE  = 2'd2
    } bcd_state_t;

    // Decimal digit to 7-segment code; non-decimal codes are blanked.
    function automatic logic [7:0] seg_code(input logic [3:0] d);
        logic [7:0] s;
        s = SEG_BLANK;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter.
// IDLE -> SHIFT (CW cycles) -> DONE -> IDLE. The operand is captured when
// start is seen in IDLE; bcd is valid while done is high.
module bin2bcd_seq
    import digi_pkg::*;
#(
    parameter int CW       = 14,
    parameter int N_DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CW-1:0]         bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*N_DIGITS-1:0] bcd
);

    localparam int BW  = 4 * N_DIGITS;
    localparam int SCW = $clog2(CW + 1);

    bcd_state_t     state, state_n;
    logic [CW-1:0]  bin_sr;
    logic [BW-1:0]  bcd_sr;
    logic [BW-1:0]  bcd_adj;
    logic [SCW-1:0] shift_cnt;

    // Add-3 correction on every BCD digit >= 5 before each shift
    always_comb begin
        bcd_adj = bcd_sr;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (bcd_sr[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            BCD_IDLE:  if (start) state_n = BCD_SHIFT;
            BCD_SHIFT: if (shift_cnt == SCW'(CW - 1)) state_n = BCD_DONE;
            BCD_DONE:  state_n = BCD_IDLE;
            default:   state_n = BCD_IDLE;
        endcase
    end

    // State register; reset abandons any conversion in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= BCD_IDLE;
        else     state <= state_n;
    end

    // Shift datapath: snapshot on start, one bit per SHIFT cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_sr    <= '0;
            bcd_sr    <= '0;
            shift_cnt <= '0;
        end else begin
            case (state)
                BCD_IDLE: begin
                    if (start) begin
                        bin_sr    <= bin;
                        bcd_sr    <= '0;
                        shift_cnt <= '0;
                    end
                end
                BCD_SHIFT: begin
                    {bcd_sr, bin_sr} <= {bcd_adj, bin_sr} << 1;
                    shift_cnt        <= shift_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != BCD_IDLE);
    assign done = (state == BCD_DONE);
    assign bcd  = bcd_sr;

endmodule

// File: rtl/multi_digit_counter.sv
// Multi-digit decimal up/down counter with multiplexed 7-segment display.
// A prescaler produces the count tick, a sequential double-dabble converts
// the binary count to BCD, and a scan divider walks the digits.
// Optional: define LEAD_ZERO_BLANK_EN to blank leading zero digits.
module multi_digit_counter
    import digi_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int CLK_FREQ  = 50_000_000,
    parameter int COUNT_HZ  = 10,
    parameter int SCAN_HZ   = 1000,
    parameter int MAX_COUNT = 10**N_DIGITS - 1,
    localparam int CW       = $clog2(MAX_COUNT + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                up_dn,
    input  logic                load,
    input  logic [CW-1:0]       load_val,
    output logic [CW-1:0]       count_out,
    output logic                wrap,
    output logic [7:0]          seg_sel,
    output logic [N_DIGITS-1:0] bit_sel
);

    localparam int PRE_DIV  = (CLK_FREQ / COUNT_HZ < 1) ? 1 : CLK_FREQ / COUNT_HZ;
    localparam int PW       = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
    localparam int SCAN_DIV = (CLK_FREQ / (SCAN_HZ * N_DIGITS) < 1) ? 1
                            : CLK_FREQ / (SCAN_HZ * N_DIGITS);
    localparam int SW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CW-1:0] MAX_C    = CW'(MAX_COUNT);
    localparam logic [PW-1:0] PRE_TOP  = PW'(PRE_DIV - 1);
    localparam logic [SW-1:0] SCAN_TOP = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_TOP  = IW'(N_DIGITS - 1);

    logic [PW-1:0]           pre;
    logic                    tick;
    logic [CW-1:0]           last_conv;
    logic                    conv_start;
    logic                    conv_busy;
    logic                    conv_done;
    logic [4*N_DIGITS-1:0]   conv_bcd;
    logic [4*N_DIGITS-1:0]   bcd_disp;
    logic [SW-1:0]           scan_cnt;
    logic [IW-1:0]           idx;
    logic [N_DIGITS-1:0]     lz_blank;
    logic [3:0]              cur_dig;
    logic                    cur_blank;

    // Free-running prescaler; tick is high for the terminal cycle only
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       pre <= '0;
        else if (tick) pre <= '0;
        else           pre <= pre + 1'b1;
    end

    assign tick = (pre == PRE_TOP);

    // Counter: load wins over tick and saturates; wrap pulses at the ends
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_out <= '0;
            wrap      <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (load) begin
                count_out <= (load_val > MAX_C) ? MAX_C : load_val;
            end else if (tick && en) begin
                if (up_dn) begin
                    if (count_out == MAX_C) begin
                        count_out <= '0;
                        wrap      <= 1'b1;
                    end else begin
                        count_out <= count_out + 1'b1;
                    end
                end else begin
                    if (count_out == '0) begin
                        count_out <= MAX_C;
                        wrap      <= 1'b1;
                    end else begin
                        count_out <= count_out - 1'b1;
                    end
                end
            end
        end
    end

    // Convert only when the count moved since the last snapshot; changes
    // while busy are picked up once the converter is back in IDLE.
    assign conv_start = (count_out != last_conv) && !conv_busy;

    // Remember which value the converter was started on
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             last_conv <= '0;
        else if (conv_start) last_conv <= count_out;
    end

    bin2bcd_seq #(
        .CW       (CW),
        .N_DIGITS (N_DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (count_out),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Display register updates atomically when a conversion completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            bcd_disp <= '0;
        else if (conv_done) bcd_disp <= conv_bcd;
    end

    // Scan divider and digit index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SCAN_TOP) begin
            scan_cnt <= '0;
            idx      <= (idx == IDX_TOP) ? '0 : idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

`ifdef LEAD_ZERO_BLANK_EN
    logic zero_above;

    // Blank every digit above the most significant non-zero one; digit 0
    // is never blanked so a zero value still shows '0'
    always_comb begin
        lz_blank   = '0;
        zero_above = 1'b1;
        for (int i = N_DIGITS - 1; i > 0; i--) begin
            zero_above  = zero_above && (bcd_disp[4*i +: 4] == 4'd0);
            lz_blank[i] = zero_above;
        end
    end
`else
    assign lz_blank = '0;
`endif

    // Pick the BCD digit currently being scanned
    always_comb begin
        cur_dig   = 4'd0;
        cur_blank = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_dig   = bcd_disp[4*i +: 4];
                cur_blank = lz_blank[i];
            end
        end
    end

    // Registered digit/segment drive so both change on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_sel <= SEG_BLANK;
            bit_sel <= '1;
        end else begin
            bit_sel <= ~(N_DIGITS'(1) << idx);
            seg_sel <= cur_blank ? SEG_BLANK : seg_code(cur_dig);
        end
    end

endmodule

// File: tb/tb_multi_digit_counter.sv
// Bench for multi_digit_counter at CLK_FREQ=1000, COUNT_HZ=100, SCAN_HZ=25.
// Reference model: decimal arithmetic on an integer count, tick phase and
// scan position derived from cycles elapsed since reset release.
module tb_multi_digit_counter;

    localparam int ND       = 4;
    localparam int MAXC     = 9999;
    localparam int CW       = $clog2(MAXC + 1);
    localparam int PRE_DIV  = 10;
    localparam int SCAN_DIV = 10;
    localparam int SETTLE   = 40;

    localparam logic [7:0] SEG_TBL [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                            8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          up_dn = 1'b1;
    logic          load = 1'b0;
    logic [CW-1:0] load_val = '0;
    logic [CW-1:0] count_out;
    logic          wrap;
    logic [7:0]    seg_sel;
    logic [ND-1:0] bit_sel;

    int total = 0, passed = 0, failed = 0;
    int m_count, m_wrap, pre, k, stable;
    int wcount;

    always #5 clk = ~clk;

    multi_digit_counter #(
        .N_DIGITS  (ND),
        .CLK_FREQ  (1000),
        .COUNT_HZ  (100),
        .SCAN_HZ   (25),
        .MAX_COUNT (MAXC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .up_dn     (up_dn),
        .load      (load),
        .load_val  (load_val),
        .count_out (count_out),
        .wrap      (wrap),
        .seg_sel   (seg_sel),
        .bit_sel   (bit_sel)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Expected segment code for decimal position d of value v
    function automatic logic [7:0] exp_seg(input int v, input int d);
        int p;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
`ifdef LEAD_ZERO_BLANK_EN
        if (d > 0 && v < p) return 8'hFF;
`endif
        return SEG_TBL[(v / p) % 10];
    endfunction

    // Digit position shown after k clock edges since reset release
    function automatic int scan_digit(input int kk);
        return ((kk - 1) / SCAN_DIV) % ND;
    endfunction

    // One clock: predict from spec rules, clock, then compare at negedge
    task automatic step();
        int nxt, nw, lv, d;
        logic [ND-1:0] bs;
        lv  = int'(load_val);
        nxt = m_count;
        nw  = 0;
        if (load) begin
            nxt = (lv > MAXC) ? MAXC : lv;
        end else if (pre == PRE_DIV - 1 && en) begin
            if (up_dn) begin
                if (m_count == MAXC) begin nxt = 0; nw = 1; end
                else nxt = m_count + 1;
            end else begin
                if (m_count == 0) begin nxt = MAXC; nw = 1; end
                else nxt = m_count - 1;
            end
        end
        if (nxt != m_count) stable = 0;
        else if (stable < 1000) stable++;
        @(posedge clk);
        m_count = nxt;
        m_wrap  = nw;
        pre     = (pre + 1) % PRE_DIV;
        k++;
        @(negedge clk);
        check("count", count_out, m_count);
        check("wrap", wrap, m_wrap);
        d  = scan_digit(k);
        bs = '1;
        bs[d] = 1'b0;
        check("bit_sel", bit_sel, bs);
        if (stable >= SETTLE) check("seg", seg_sel, exp_seg(m_count, d));
    endtask

    task automatic model_reset();
        m_count = 0;
        m_wrap  = 0;
        pre     = 0;
        k       = 0;
        stable  = 1000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        load = 1'b0;
        en   = 1'b0;
        #1;
        check("rst_count", count_out, 0);
        check("rst_bit_sel", bit_sel, 4'hF);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check("rel_seg", seg_sel, 8'hFF);
        check("rel_wrap", wrap, 0);
    endtask

    task automatic pulse_load(input int v);
        load     = 1'b1;
        load_val = CW'(v);
        step();
        load     = 1'b0;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Count up from reset: first increment on the 10th edge
        en = 1'b1; up_dn = 1'b1;
        repeat (10) step();
        check("first_inc", count_out, 1);
        repeat (15) step();
        check("count_25", count_out, 2);

        // Up wrap at terminal count, one-cycle pulse
        pulse_load(9998);
        check("load_9998", count_out, 9998);
        wcount = 0;
        repeat (20) begin step(); wcount += int'(wrap); end
        check("wrap_pulses_up", wcount, 1);

        // Down wrap from 0
        up_dn = 1'b0;
        pulse_load(0);
        wcount = 0;
        repeat (10) begin step(); wcount += int'(wrap); end
        check("down_wrap_val", count_out, 9999);
        check("wrap_pulses_dn", wcount, 1);

        // Saturating load, hold with en low
        en = 1'b0;
        pulse_load(12000);
        check("load_sat", count_out, 9999);
        repeat (30) step();
        check("hold", count_out, 9999);

        // Display of 1234 and of 7 (leading zeros), scanned across all digits
        pulse_load(1234);
        repeat (SETTLE + 45) step();
        pulse_load(7);
        repeat (SETTLE + 45) step();

        // Conversion latency: 0 -> 8888 changes every digit
        pulse_load(0);
        repeat (SETTLE + 5) step();
        pulse_load(8888);
        repeat (16) step();
        check("lat_old", seg_sel, exp_seg(0, scan_digit(k)));
        step();
        check("lat_new", seg_sel, 8'h80);
        repeat (30) step();

        // Reset while the converter is shifting
        pulse_load(5555);
        repeat (3) step();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_count", count_out, 0);
        check("arst_wrap", wrap, 0);
        check("arst_seg", seg_sel, 8'hFF);
        check("arst_bit_sel", bit_sel, 4'hF);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (SETTLE + 20) step();
        check("post_rst_seg0", exp_seg(0, 0), 8'hC0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            en       = 1'(($urandom % 4) != 0);
            up_dn    = 1'($urandom % 2);
            load     = 1'(($urandom % 16) == 0);
            load_val = CW'($urandom_range(0, 16383));
            step();
        end
        load = 1'b0;
        en   = 1'b0;
        repeat (SETTLE + 45) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
